arbitro_demux_fifo: RTL and testbench

- Parametrised successor of the arbiter-side demux. Routes each incoming word to one of NUM_CH output channels, selected by a field inside the word.
- Each channel has a small first-word-fall-through FIFO. Upstream sees a valid/ready handshake and stalls only when the targeted channel is full.
- Sits between the arbiter mux stage and the per-lane consumers, replacing the unbuffered, latch-prone combinational demux.

---
 rtl/arbitro_demux_fifo.sv | 92 +++++++++
 tb/tb_arbitro_demux_fifo.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_demux_fifo.sv
// Select-field demultiplexer feeding one first-word-fall-through FIFO per output channel.
// Upstream stalls only when the addressed channel is full; out-of-range selects are counted and dropped.
module arbitro_demux_fifo #(
  parameter int DATA_W   = 6,
  parameter int NUM_CH   = 2,
  parameter int SEL_LSB  = 4,
  parameter int SEL_W    = 1,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH-1:0]        pop,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  output logic [NUM_CH-1:0]        full,
  output logic [NUM_CH-1:0]        almost_full,
  output logic [7:0]               err_sel_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [SEL_W-1:0]  sel;
  logic              sel_ok;
  logic [NUM_CH-1:0] push_sel;

  assign sel    = in_data[SEL_LSB +: SEL_W];
  assign sel_ok = (32'(sel) < 32'(NUM_CH));

  // A full channel still accepts when its head is popped in the same edge.
  always_comb begin
    in_ready = 1'b1;
    push_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_ok && (32'(sel) == 32'(i))) begin
        in_ready    = ~full[i] | pop[i];
        push_sel[i] = in_valid & (~full[i] | pop[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_sel_cnt <= 8'd0;
    end else if (in_valid && !sel_ok && (err_sel_cnt != 8'hFF)) begin
      err_sel_cnt <= err_sel_cnt + 8'd1;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;
    logic              do_push;
    logic              do_pop;

    assign do_push = push_sel[ch];
    assign do_pop  = pop[ch] & (occ != '0);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        occ    <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        unique case ({do_push, do_pop})
          2'b10:   occ <= occ + OCC_W'(1);
          2'b01:   occ <= occ - OCC_W'(1);
          default: occ <= occ;
        endcase
      end
    end

    // Storage is left unreset; the output mask hides stale entries.
    always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= in_data;
    end

    assign out_valid[ch]   = (occ != '0);
    assign full[ch]        = (occ == OCC_W'(DEPTH));
    assign almost_full[ch] = (occ >= OCC_W'(AF_LEVEL));
    assign out_data[ch*DATA_W +: DATA_W] = out_valid[ch] ? mem[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_arbitro_demux_fifo.sv
// Bench for arbitro_demux_fifo: fixed vector table, randomized run against a queue model,
// reset corner case and out-of-range select counting on a 3-channel instance.
module tb_arbitro_demux_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  pop;
  logic [11:0] out_data;
  logic [1:0]  out_valid;
  logic [1:0]  full;
  logic [1:0]  almost_full;
  logic [7:0]  err_sel_cnt;

  logic [5:0]  b_in_data;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [2:0]  b_pop;
  logic [17:0] b_out_data;
  logic [2:0]  b_out_valid;
  logic [2:0]  b_full;
  logic [2:0]  b_almost_full;
  logic [7:0]  b_err_sel_cnt;

  int checks = 0;
  int errors = 0;

  logic [5:0] mq0[$];
  logic [5:0] mq1[$];

  typedef struct {
    logic [5:0] din;
    logic       vld;
    logic [1:0] pp;
    logic       rdy;
    logic [1:0] ov;
    logic [1:0] fl;
    logic [1:0] af;
    logic [5:0] d0;
    logic [5:0] d1;
  } vec_t;

  vec_t tbl[18];

  always #5 clk = ~clk;

  arbitro_demux_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pop         (pop),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .full        (full),
    .almost_full (almost_full),
    .err_sel_cnt (err_sel_cnt)
  );

  arbitro_demux_fifo #(
    .DATA_W(6), .NUM_CH(3), .SEL_LSB(4), .SEL_W(2), .DEPTH(4), .AF_LEVEL(3)
  ) dut3 (
    .clk         (clk),
    .reset       (reset),
    .in_data     (b_in_data),
    .in_valid    (b_in_valid),
    .in_ready    (b_in_ready),
    .pop         (b_pop),
    .out_data    (b_out_data),
    .out_valid   (b_out_valid),
    .full        (b_full),
    .almost_full (b_almost_full),
    .err_sel_cnt (b_err_sel_cnt)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] d, input logic v, input logic [1:0] p);
    in_data  = d;
    in_valid = v;
    pop      = p;
    #1;
  endtask

  // Expected outputs follow directly from the queue contents and the current inputs.
  task automatic checkModel();
    int s0, s1;
    logic exp_rdy;
    s0 = mq0.size();
    s1 = mq1.size();
    if (in_data[4]) exp_rdy = (s1 < 4) || pop[1];
    else            exp_rdy = (s0 < 4) || pop[0];
    checkOutput("rnd_ready", in_ready, exp_rdy);
    checkOutput("rnd_valid", out_valid, {s1 > 0, s0 > 0});
    checkOutput("rnd_full", full, {s1 == 4, s0 == 4});
    checkOutput("rnd_afull", almost_full, {s1 >= 3, s0 >= 3});
    checkOutput("rnd_data0", out_data[5:0], (s0 > 0) ? mq0[0] : 6'h00);
    checkOutput("rnd_data1", out_data[11:6], (s1 > 0) ? mq1[0] : 6'h00);
    checkOutput("rnd_err", err_sel_cnt, 0);
  endtask

  task automatic modelEdge();
    logic acc;
    if (in_data[4]) acc = in_valid && ((mq1.size() < 4) || (pop[1] && mq1.size() > 0));
    else            acc = in_valid && ((mq0.size() < 4) || (pop[0] && mq0.size() > 0));
    if (pop[0] && mq0.size() > 0) void'(mq0.pop_front());
    if (pop[1] && mq1.size() > 0) void'(mq1.pop_front());
    if (acc) begin
      if (in_data[4]) mq1.push_back(in_data);
      else            mq0.push_back(in_data);
    end
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    mq0.delete();
    mq1.delete();
  endtask

  initial begin
    tbl[0]  = '{6'h05, 1'b1, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 6'h00, 6'h00};
    tbl[1]  = '{6'h15, 1'b1, 2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 6'h05, 6'h00};
    tbl[2]  = '{6'h00, 1'b0, 2'b00, 1'b1, 2'b11, 2'b00, 2'b00, 6'h05, 6'h15};
    tbl[3]  = '{6'h00, 1'b0, 2'b11, 1'b1, 2'b11, 2'b00, 2'b00, 6'h05, 6'h15};
    tbl[4]  = '{6'h00, 1'b0, 2'b11, 1'b1, 2'b00, 2'b00, 2'b00, 6'h00, 6'h00};
    tbl[5]  = '{6'h00, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 6'h00, 6'h00};
    tbl[6]  = '{6'h01, 1'b1, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 6'h00, 6'h00};
    tbl[7]  = '{6'h02, 1'b1, 2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 6'h01, 6'h00};
    tbl[8]  = '{6'h03, 1'b1, 2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 6'h01, 6'h00};
    tbl[9]  = '{6'h04, 1'b1, 2'b00, 1'b1, 2'b01, 2'b00, 2'b01, 6'h01, 6'h00};
    tbl[10] = '{6'h05, 1'b1, 2'b00, 1'b0, 2'b01, 2'b01, 2'b01, 6'h01, 6'h00};
    tbl[11] = '{6'h11, 1'b1, 2'b00, 1'b1, 2'b01, 2'b01, 2'b01, 6'h01, 6'h00};
    tbl[12] = '{6'h06, 1'b1, 2'b01, 1'b1, 2'b11, 2'b01, 2'b01, 6'h01, 6'h11};
    tbl[13] = '{6'h00, 1'b0, 2'b01, 1'b1, 2'b11, 2'b01, 2'b01, 6'h02, 6'h11};
    tbl[14] = '{6'h00, 1'b0, 2'b01, 1'b1, 2'b11, 2'b00, 2'b01, 6'h03, 6'h11};
    tbl[15] = '{6'h00, 1'b0, 2'b01, 1'b1, 2'b11, 2'b00, 2'b00, 6'h04, 6'h11};
    tbl[16] = '{6'h00, 1'b0, 2'b11, 1'b1, 2'b11, 2'b00, 2'b00, 6'h06, 6'h11};
    tbl[17] = '{6'h00, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 6'h00, 6'h00};

    reset      = 1'b1;
    in_data    = '0;
    in_valid   = 1'b0;
    pop        = '0;
    b_in_data  = '0;
    b_in_valid = 1'b0;
    b_pop      = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("rst_valid", out_valid, 2'b00);
    checkOutput("rst_full", full, 2'b00);
    checkOutput("rst_afull", almost_full, 2'b00);
    checkOutput("rst_data", out_data, 12'h000);
    checkOutput("rst_err", err_sel_cnt, 8'd0);
    checkOutput("rst_ready", in_ready, 1'b1);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].din, tbl[i].vld, tbl[i].pp);
      checkOutput($sformatf("vec%0d_ready", i), in_ready, tbl[i].rdy);
      checkOutput($sformatf("vec%0d_valid", i), out_valid, tbl[i].ov);
      checkOutput($sformatf("vec%0d_full", i), full, tbl[i].fl);
      checkOutput($sformatf("vec%0d_afull", i), almost_full, tbl[i].af);
      checkOutput($sformatf("vec%0d_data0", i), out_data[5:0], tbl[i].d0);
      checkOutput($sformatf("vec%0d_data1", i), out_data[11:6], tbl[i].d1);
      @(posedge clk);
      #1;
    end

    applyStimulus(6'h00, 1'b0, 2'b00);
    pulseReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(6'($urandom), 1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3) & $urandom_range(0, 3)));
      checkModel();
      @(posedge clk);
      modelEdge();
      #1;
    end

    // Asynchronous reset in the middle of a cycle with three words in channel 0.
    applyStimulus(6'h00, 1'b0, 2'b00);
    pulseReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(6'(8 + i), 1'b1, 2'b00);
      @(posedge clk);
      #1;
    end
    applyStimulus(6'h00, 1'b0, 2'b00);
    checkOutput("pre_rst_valid", out_valid, 2'b01);
    checkOutput("pre_rst_afull", almost_full, 2'b01);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_valid", out_valid, 2'b00);
    checkOutput("midrst_data", out_data, 12'h000);
    checkOutput("midrst_full", full, 2'b00);
    checkOutput("midrst_afull", almost_full, 2'b00);
    checkOutput("midrst_err", err_sel_cnt, 8'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("postrst_ready", in_ready, 1'b1);
    checkOutput("postrst_valid", out_valid, 2'b00);

    // Three-channel instance: sel=3 is out of range, sel=2 routes to channel 2.
    b_in_data  = 6'h35;
    b_in_valid = 1'b1;
    #1;
    checkOutput("oor_ready", b_in_ready, 1'b1);
    checkOutput("oor_err_before", b_err_sel_cnt, 8'd0);
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    #1;
    checkOutput("oor_err_one", b_err_sel_cnt, 8'd1);
    checkOutput("oor_no_fifo", b_out_valid, 3'b000);
    b_in_data  = 6'h25;
    b_in_valid = 1'b1;
    #1;
    checkOutput("ch2_ready", b_in_ready, 1'b1);
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    #1;
    checkOutput("ch2_valid", b_out_valid, 3'b100);
    checkOutput("ch2_data", b_out_data[17:12], 6'h25);
    checkOutput("ch2_err", b_err_sel_cnt, 8'd1);
    b_in_data  = 6'h3F;
    b_in_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1 b_in_valid = 1'b0;
    #1;
    checkOutput("oor_saturate", b_err_sel_cnt, 8'd255);
    checkOutput("oor_sat_valid", b_out_valid, 3'b100);
    checkOutput("oor_sat_data0", b_out_data[5:0], 6'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
